// File: rtl/instruction_encoder.sv
// Purpose : packs MIPS R/I/J field bundles into 32-bit words and streams them,
//           with incrementing byte addresses, to the instruction-memory write port.
// Latency : 1 cycle from input accept to out_valid; 1 word/cycle with out_ready held high.
// Backpressure: out_valid/out_ready holding register; in_ready drops while the
//           holding register is full and not draining, or once the word count is reached.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   start, base_addr, word_count   load request, sampled only in IDLE
//   in_valid/in_ready, fmt, op, func, rs, rt, rd, sa, imm, addr   field bundle input
//   out_valid/out_ready, out_word, out_addr                       memory write stream
//   busy, done, err            status: not idle / one-cycle completion / sticky bad fmt
module instruction_encoder #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        fmt,
    input  logic [5:0]        op,
    input  logic [5:0]        func,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        sa,
    input  logic [15:0]       imm,
    input  logic [25:0]       addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] FMT_R = 2'd0;
    localparam logic [1:0] FMT_I = 2'd1;
    localparam logic [1:0] FMT_J = 2'd2;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [CNT_W-1:0]  rem_q;
    logic [31:0]       enc_word;
    logic              in_acc;
    logic              legal_acc;
    logic              illegal_acc;
    logic              out_hs;
    logic              load;

    // Combinational field packing; fields not used by the format are ignored.
    always_comb begin
        enc_word = 32'd0;
        case (fmt)
            FMT_R:   enc_word = {op, rs, rt, rd, sa, func};
            FMT_I:   enc_word = {op, rs, rt, imm};
            FMT_J:   enc_word = {op, addr};
            default: enc_word = 32'd0;
        endcase
    end

    assign load        = (state_q == IDLE) && start;
    assign out_hs      = out_valid && out_ready;
    // Accept only while words remain and the holding register is empty or emptying.
    assign in_ready    = (state_q == RUN) && (rem_q != '0) && (!out_valid || out_ready);
    assign in_acc      = in_valid && in_ready;
    assign legal_acc   = in_acc && (fmt != 2'd3);
    assign illegal_acc = in_acc && (fmt == 2'd3);
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (word_count == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // The last legal word moves us on; illegal bundles never count.
                if ((legal_acc && (rem_q == CNT_W'(1))) || (rem_q == '0)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!out_valid || out_hs) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            rem_q <= '0;
            err   <= 1'b0;
        end else if (load) begin
            ptr_q <= base_addr;
            rem_q <= word_count;
            err   <= 1'b0;
        end else begin
            if (legal_acc) begin
                // Wraps modulo 2^ADDR_W without any indication.
                ptr_q <= ptr_q + ADDR_W'(4);
                rem_q <= rem_q - CNT_W'(1);
            end
            if (illegal_acc) begin
                err <= 1'b1;
            end
        end
    end

    // Output holding register: a same-cycle accept wins over the handshake clear,
    // which is what sustains one word per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_word  <= 32'd0;
            out_addr  <= '0;
        end else if (legal_acc) begin
            out_valid <= 1'b1;
            out_word  <= enc_word;
            out_addr  <= ptr_q;
        end else if (out_hs) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
module tb_instruction_encoder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] word_count;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  fmt;
    logic [5:0]  op;
    logic [5:0]  func;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [15:0] imm;
    logic [25:0] addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [31:0] out_addr;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    instruction_encoder #(.ADDR_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .op(op), .func(func), .rs(rs), .rt(rt), .rd(rd), .sa(sa),
        .imm(imm), .addr(addr), .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_addr(out_addr), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  fmt;
        logic [5:0]  op;
        logic [5:0]  func;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sa;
        logic [15:0] imm;
        logic [25:0] addr;
        logic [31:0] exp_word;
    } vec_t;

    typedef struct {
        logic [31:0] w;
        logic [31:0] a;
    } exp_t;

    vec_t vecs[6];
    exp_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Reference encoding from field positions as plain arithmetic.
    function automatic logic [31:0] model_word(input vec_t v);
        longint r;
        r = longint'(v.op) * 64'd67108864;
        case (v.fmt)
            2'd0: r = r + longint'(v.rs) * 2097152 + longint'(v.rt) * 65536
                    + longint'(v.rd) * 2048 + longint'(v.sa) * 64 + longint'(v.func);
            2'd1: r = r + longint'(v.rs) * 2097152 + longint'(v.rt) * 65536 + longint'(v.imm);
            default: r = r + longint'(v.addr);
        endcase
        return r[31:0];
    endfunction

    task automatic drive(input vec_t v, input logic vld);
        fmt = v.fmt; op = v.op; func = v.func; rs = v.rs; rt = v.rt;
        rd = v.rd; sa = v.sa; imm = v.imm; addr = v.addr; in_valid = vld;
    endtask

    task automatic start_load(input logic [31:0] b, input logic [15:0] c);
        @(negedge clk);
        start = 1'b1; base_addr = b; word_count = c;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Sample point: 1 time unit before the next rising edge.
    task automatic cyc();
        @(negedge clk);
        #4;
    endtask

    function automatic vec_t mk(input logic [1:0] f, input logic [5:0] o, input logic [4:0] s,
                                input logic [4:0] t, input logic [4:0] d, input logic [4:0] a,
                                input logic [5:0] fn, input logic [15:0] im,
                                input logic [25:0] ad, input logic [31:0] e);
        vec_t v;
        v.fmt = f; v.op = o; v.rs = s; v.rt = t; v.rd = d; v.sa = a;
        v.func = fn; v.imm = im; v.addr = ad; v.exp_word = e;
        return v;
    endfunction

    vec_t v;
    vec_t bad;

    initial begin
        // Unused fields deliberately carry junk in several entries.
        vecs[0] = mk(2'd0, 6'h00, 5'd1,  5'd2,  5'd3,  5'd0,  6'h20, 16'h0000, 26'h0,       32'h00221820);
        vecs[1] = mk(2'd1, 6'h08, 5'd0,  5'd8,  5'd31, 5'd31, 6'h3F, 16'h0005, 26'h3FFFFFF, 32'h20080005);
        vecs[2] = mk(2'd2, 6'h02, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h0100000, 32'h08100000);
        vecs[3] = mk(2'd0, 6'h3F, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'h1234, 26'h0,       32'hFFFFFFFF);
        vecs[4] = mk(2'd1, 6'h23, 5'd29, 5'd31, 5'd7,  5'd9,  6'h11, 16'hFFFC, 26'h155,     32'h8FBFFFFC);
        vecs[5] = mk(2'd2, 6'h03, 5'd5,  5'd6,  5'd7,  5'd8,  6'h09, 16'hAAAA, 26'h3FFFFFF, 32'h0FFFFFFF);
        bad = mk(2'd3, 6'h3F, 5'd1, 5'd1, 5'd1, 5'd1, 6'h01, 16'h1, 26'h1, 32'h0);

        rst_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
        out_ready = 1'b0;
        drive(vecs[0], 1'b0);
        #12;
        check("reset_ctrl", {out_valid, in_ready, busy, done, err}, 5'b0);
        check("reset_word", out_word, 32'h0);
        check("reset_addr", out_addr, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        // Table: one word per load, checked for word, address and done timing.
        for (int i = 0; i < 6; i++) begin
            start_load(32'h100 + 32'(i) * 32'h10, 16'd1);
            @(negedge clk); drive(vecs[i], 1'b1); out_ready = 1'b1;
            #4 check($sformatf("tbl%0d_in_ready", i), in_ready, 1'b1);
            cyc(); in_valid = 1'b0;
            check($sformatf("tbl%0d_valid", i), out_valid, 1'b1);
            check($sformatf("tbl%0d_word", i), out_word, vecs[i].exp_word);
            check($sformatf("tbl%0d_model", i), out_word, model_word(vecs[i]));
            check($sformatf("tbl%0d_addr", i), out_addr, 32'h100 + 32'(i) * 32'h10);
            cyc();
            check($sformatf("tbl%0d_done", i), {done, out_valid, err}, 3'b100);
            cyc();
            check($sformatf("tbl%0d_done_end", i), {done, busy}, 2'b00);
        end

        // Back-to-back I then J, no bubble.
        start_load(32'h400, 16'd2);
        @(negedge clk); drive(vecs[1], 1'b1); out_ready = 1'b1;
        #4 check("b2b_rdy0", in_ready, 1'b1);
        @(negedge clk); drive(vecs[2], 1'b1);
        #4 check("b2b_w0", {out_valid, in_ready, out_word, out_addr}, {2'b11, 32'h20080005, 32'h400});
        @(negedge clk); in_valid = 1'b0;
        #4 check("b2b_w1", {out_valid, out_word, out_addr}, {1'b1, 32'h08100000, 32'h404});
        cyc();
        check("b2b_done", {done, out_valid}, 2'b10);

        // Backpressure: second bundle waits while out_ready is low.
        start_load(32'h800, 16'd2);
        @(negedge clk); drive(vecs[0], 1'b1); out_ready = 1'b0;
        #4 check("bp_rdy0", in_ready, 1'b1);
        @(negedge clk); drive(vecs[3], 1'b1);
        for (int k = 0; k < 3; k++) begin
            #4 check($sformatf("bp_stall%0d", k),
                     {out_valid, in_ready, out_word, out_addr}, {2'b10, 32'h00221820, 32'h800});
            @(negedge clk);
        end
        out_ready = 1'b1;
        #4 check("bp_rel", {out_valid, in_ready, out_word, out_addr}, {2'b11, 32'h00221820, 32'h800});
        @(negedge clk); in_valid = 1'b0;
        #4 check("bp_w1", {out_valid, out_word, out_addr}, {1'b1, 32'hFFFFFFFF, 32'h804});
        cyc();
        check("bp_done", {done, out_valid}, 2'b10);

        // Illegal format consumed, then one legal word; err sticky until next start.
        start_load(32'hC00, 16'd1);
        @(negedge clk); drive(bad, 1'b1); out_ready = 1'b1;
        #4 check("ill_rdy", in_ready, 1'b1);
        @(negedge clk); drive(vecs[0], 1'b1);
        #4 check("ill_err", {err, out_valid, in_ready}, 3'b101);
        @(negedge clk); in_valid = 1'b0;
        #4 check("ill_word", {out_valid, out_word, out_addr}, {1'b1, 32'h00221820, 32'hC00});
        cyc();
        check("ill_done", {done, err, out_valid}, 3'b110);
        cyc();
        check("ill_sticky", {done, err, busy}, 3'b010);
        // Zero-count load: done next cycle, no output, err cleared by start.
        start_load(32'h0, 16'd0);
        cyc();
        check("zero_done", {done, err, out_valid}, 3'b100);
        cyc();
        check("zero_idle", {done, busy}, 2'b00);

        // Address wrap.
        start_load(32'hFFFFFFFC, 16'd2);
        @(negedge clk); drive(vecs[4], 1'b1); out_ready = 1'b1;
        @(negedge clk); drive(vecs[5], 1'b1);
        #4 check("wrap_a0", {out_valid, out_addr}, {1'b1, 32'hFFFFFFFC});
        @(negedge clk); in_valid = 1'b0;
        #4 check("wrap_a1", {out_valid, out_addr, out_word}, {1'b1, 32'h0, 32'h0FFFFFFF});
        cyc();
        check("wrap_done", done, 1'b1);

        // Async reset while a word is pending.
        begin
            logic saw_done;
            saw_done = 1'b0;
            start_load(32'h40, 16'd2);
            @(negedge clk); drive(vecs[0], 1'b1); out_ready = 1'b0;
            @(negedge clk); in_valid = 1'b0;
            #4 check("rst_pre", out_valid, 1'b1);
            #2 rst_n = 1'b0;
            #1 check("rst_async", {out_valid, in_ready, busy, done, err, out_word, out_addr}, 69'b0);
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (k == 2) rst_n = 1'b1;
                #4 if (done) saw_done = 1'b1;
            end
            check("rst_no_done", saw_done, 1'b0);
            check("rst_idle", {busy, out_valid}, 2'b00);
        end

        // Randomized loads against the queue model.
        for (int ld = 0; ld < 30; ld++) begin
            logic [31:0] b;
            int cnt, acc, got, guard;
            logic pending, errx, got_done, err_at_done, overrun;
            b = (ld % 5 == 0) ? (32'hFFFFFFF0 | (32'($urandom_range(0, 3)) * 4)) : ($urandom & 32'hFFFFFFFC);
            cnt = $urandom_range(1, 6);
            acc = 0; got = 0; pending = 0; errx = 0; got_done = 0; err_at_done = 0; overrun = 0;
            exp_q.delete();
            start_load(b, 16'(cnt));
            for (guard = 0; guard < 300 && !got_done; guard++) begin
                @(negedge clk);
                if (!pending && acc < cnt && $urandom_range(0, 3) != 0) begin
                    v.fmt = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                    v.op = 6'($urandom); v.func = 6'($urandom); v.rs = 5'($urandom);
                    v.rt = 5'($urandom); v.rd = 5'($urandom); v.sa = 5'($urandom);
                    v.imm = 16'($urandom); v.addr = 26'($urandom); v.exp_word = 32'h0;
                    pending = 1'b1;
                end
                drive(v, pending || (acc == cnt));
                out_ready = ($urandom_range(0, 3) != 0);
                #4;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("rnd%0d_extra_word", ld), out_word, 32'h0);
                    end else begin
                        check($sformatf("rnd%0d_word", ld), out_word, exp_q[0].w);
                        check($sformatf("rnd%0d_addr", ld), out_addr, exp_q[0].a);
                        void'(exp_q.pop_front());
                    end
                    got++;
                end
                if (in_valid && in_ready) begin
                    if (acc == cnt) overrun = 1'b1;
                    else if (fmt == 2'd3) errx = 1'b1;
                    else begin
                        exp_q.push_back('{w: model_word(v), a: b + 32'(acc) * 32'd4});
                        acc++;
                    end
                    pending = 1'b0;
                end
                if (done) begin
                    got_done = 1'b1;
                    err_at_done = err;
                end
            end
            in_valid = 1'b0;
            check($sformatf("rnd%0d_done", ld), got_done, 1'b1);
            check($sformatf("rnd%0d_count", ld), got, cnt);
            check($sformatf("rnd%0d_err", ld), err_at_done, errx);
            check($sformatf("rnd%0d_overrun", ld), overrun, 1'b0);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
